// File: rtl/apb_i2c_regfile.sv
// APB register file for an I2C core: TX/RX FIFOs, CONFIG/TIMEOUT, and interrupt status/enable.
// Optional macro APB_I2C_WAIT_STATE_EN inserts one wait state into every APB access.
module apb_i2c_regfile #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CFG_W      = 14
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_EMPTY,
    input  logic              TX_RD_EN,
    input  logic              RX_WR_EN,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic              RX_FULL,
    input  logic              ERROR,
    output logic [CFG_W-1:0]  I2C_CONFIG,
    output logic [CFG_W-1:0]  I2C_TIMEOUT,
    output logic              IRQ
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [2:0] A_TX   = 3'd0;
    localparam logic [2:0] A_RX   = 3'd1;
    localparam logic [2:0] A_CFG  = 3'd2;
    localparam logic [2:0] A_TMO  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;
    localparam logic [2:0] A_IEN  = 3'd5;
    localparam logic [2:0] A_IST  = 3'd6;

    logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0]     r_tx_cnt, r_rx_cnt;
    logic [CFG_W-1:0]  r_cfg, r_tmo;
    logic [3:0]        r_irq_en;
    logic              r_ovf, r_errs, r_err_d, r_irq;

    logic        w_access, w_ready, w_done, w_mapped, w_bad;
    logic        w_wr_done, w_rd_done;
    logic [2:0]  w_idx;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_ovf, w_err_rise;
    logic [1:0]  w_clr;
    logic [3:0]  w_irq_stat;
    logic [15:0] w_status;

    assign w_access = PSELx & PENABLE;

`ifdef APB_I2C_WAIT_STATE_EN
    // First access cycle always stalls; r_wait marks the second one.
    logic r_wait;
    always_ff @(posedge PCLK) begin
        if (PRESET) r_wait <= 1'b0;
        else        r_wait <= w_access & ~r_wait;
    end
    assign w_ready = w_access & r_wait;
`else
    assign w_ready = w_access;
`endif

    assign PREADY    = w_ready;
    assign w_done    = w_access & w_ready;
    assign w_idx     = PADDR[4:2];
    assign w_mapped  = (PADDR[31:5] == 27'd0) && (PADDR[1:0] == 2'd0) && (w_idx != 3'd7);
    assign w_wr_done = w_done & PWRITE & w_mapped;
    assign w_rd_done = w_done & ~PWRITE & w_mapped;

    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);

    // Error response decode for the current access.
    always_comb begin
        w_bad = 1'b0;
        if (!w_mapped) begin
            w_bad = 1'b1;
        end else begin
            case (w_idx)
                A_TX:    w_bad = ~PWRITE | w_tx_full;
                A_RX:    w_bad = PWRITE | w_rx_empty;
                A_STAT:  w_bad = PWRITE;
                default: w_bad = 1'b0;
            endcase
        end
    end
    assign PSLVERR = w_done & w_bad;

    assign w_tx_push  = w_wr_done && (w_idx == A_TX) && !w_tx_full;
    assign w_tx_pop   = TX_RD_EN && !w_tx_empty;
    assign w_rx_push  = RX_WR_EN && !w_rx_full;
    assign w_rx_pop   = w_rd_done && (w_idx == A_RX) && !w_rx_empty;
    assign w_rx_ovf   = RX_WR_EN && w_rx_full;
    assign w_err_rise = ERROR && !r_err_d;
    assign w_clr      = (w_wr_done && (w_idx == A_IST)) ? PWDATA[3:2] : 2'b00;
    assign w_irq_stat = {r_errs, r_ovf, ~w_rx_empty, w_tx_empty};
    assign w_status   = {8'(r_rx_cnt), 8'(r_tx_cnt)};

    always_comb begin
        PRDATA = '0;
        if (w_access && !PWRITE && w_mapped) begin
            case (w_idx)
                A_RX:    if (!w_rx_empty) PRDATA = r_rx_mem[r_rx_rp];
                A_CFG:   PRDATA = DATA_W'(r_cfg);
                A_TMO:   PRDATA = DATA_W'(r_tmo);
                A_STAT:  PRDATA = DATA_W'(w_status);
                A_IEN:   PRDATA = DATA_W'(r_irq_en);
                A_IST:   PRDATA = DATA_W'(w_irq_stat);
                default: PRDATA = '0;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge PCLK) begin
        if (!PRESET && w_tx_push) r_tx_mem[r_tx_wp] <= PWDATA;
        if (!PRESET && w_rx_push) r_rx_mem[r_rx_wp] <= RX_DATA;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_cfg    <= '0;
            r_tmo    <= '0;
            r_irq_en <= '0;
            r_ovf    <= 1'b0;
            r_errs   <= 1'b0;
            r_err_d  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            if (w_wr_done && (w_idx == A_CFG)) r_cfg    <= PWDATA[CFG_W-1:0];
            if (w_wr_done && (w_idx == A_TMO)) r_tmo    <= PWDATA[CFG_W-1:0];
            if (w_wr_done && (w_idx == A_IEN)) r_irq_en <= PWDATA[3:0];
            // Sticky bits: a set event in the same cycle beats a W1C.
            r_ovf   <= w_rx_ovf   | (r_ovf  & ~w_clr[0]);
            r_errs  <= w_err_rise | (r_errs & ~w_clr[1]);
            r_err_d <= ERROR;
            r_irq   <= |(w_irq_stat & r_irq_en);
        end
    end

    assign TX_DATA     = r_tx_mem[r_tx_rp];
    assign TX_EMPTY    = w_tx_empty;
    assign RX_FULL     = w_rx_full;
    assign I2C_CONFIG  = r_cfg;
    assign I2C_TIMEOUT = r_tmo;
    assign IRQ         = r_irq;

endmodule

// File: tb/tb_apb_i2c_regfile.sv
// Scoreboard bench for apb_i2c_regfile: TX/RX data queues plus register and interrupt checks.
module tb_apb_i2c_regfile;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CFG_W      = 14;
`ifdef APB_I2C_WAIT_STATE_EN
    localparam int WAITS = 1;
`else
    localparam int WAITS = 0;
`endif

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              PSELx = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [31:0]       PADDR = '0;
    logic [DATA_W-1:0] PWDATA = '0;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY, PSLVERR;
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_EMPTY;
    logic              TX_RD_EN = 1'b0;
    logic              RX_WR_EN = 1'b0;
    logic [DATA_W-1:0] RX_DATA = '0;
    logic              RX_FULL;
    logic              ERROR = 1'b0;
    logic [CFG_W-1:0]  I2C_CONFIG, I2C_TIMEOUT;
    logic              IRQ;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    int n_cmp = 0;
    int n_err = 0;
    int last_waits = 0;

    apb_i2c_regfile #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CFG_W(CFG_W)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TX_DATA(TX_DATA), .TX_EMPTY(TX_EMPTY), .TX_RD_EN(TX_RD_EN),
        .RX_WR_EN(RX_WR_EN), .RX_DATA(RX_DATA), .RX_FULL(RX_FULL),
        .ERROR(ERROR), .I2C_CONFIG(I2C_CONFIG), .I2C_TIMEOUT(I2C_TIMEOUT), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // side: 0 none, 1 raise ERROR at the completing edge, 2 core pop at the completing edge
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int side, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        #1 chk("pready_setup", 32'(PREADY), 0);
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        n = 0;
        while (!PREADY && n < 4) begin
            @(negedge PCLK); #1;
            n++;
        end
        last_waits = n;
        if (!PREADY) chk("pready_timeout", 0, 1);
        if (side == 1) ERROR = 1'b1;
        if (side == 2) begin
            chk("tx_head_at_pop", TX_DATA, txq.pop_front());
            TX_RD_EN = 1'b1;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0; ERROR = 1'b0; TX_RD_EN = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err, input int side = 0);
        logic [31:0] r;
        logic e;
        apb_xfer(1'b1, a, d, side, r, e);
        chk($sformatf("wr_slverr@%0h", a), 32'(e), 32'(exp_err));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] r;
        logic e;
        apb_xfer(1'b0, a, 32'h0, 0, r, e);
        chk($sformatf("rd_slverr@%0h", a), 32'(e), 32'(exp_err));
        chk($sformatf("rd_data@%0h", a), r, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic e;
        repeat (3) @(negedge PCLK);
        #1;
        chk("rst_tx_empty", 32'(TX_EMPTY), 1);
        chk("rst_rx_full", 32'(RX_FULL), 0);
        chk("rst_irq", 32'(IRQ), 0);
        chk("rst_cfg", 32'(I2C_CONFIG), 0);
        chk("rst_pready", 32'(PREADY), 0);
        chk("rst_pslverr", 32'(PSLVERR), 0);
        PRESET = 1'b0;
        @(negedge PCLK); #1;
        chk("idle_pready", 32'(PREADY), 0);

        // CONFIG / TIMEOUT
        wr(32'h08, 32'h0000_1234, 1'b0);
        chk("cfg_out", 32'(I2C_CONFIG), 32'h1234);
        chk("wait_states", 32'(last_waits), 32'(WAITS));
        rd(32'h08, 32'h1234, 1'b0);
        wr(32'h0C, 32'hFFFF_FFFF, 1'b0);
        chk("tmo_out", 32'(I2C_TIMEOUT), 32'h3FFF);
        rd(32'h0C, 32'h3FFF, 1'b0);

        // RX empty read
        rd(32'h04, 32'h0, 1'b1);

        // TX fill past full
        for (int i = 0; i < 9; i++) begin
            d = 32'hA500_0000 + 32'(i);
            e = (txq.size() == FIFO_DEPTH);
            if (!e) txq.push_back(d);
            wr(32'h00, d, e);
            if (i == 0) chk("tx_empty_drop", 32'(TX_EMPTY), 0);
        end
        rd(32'h10, 32'h0000_0008, 1'b0);
        rd(32'h00, 32'h0, 1'b1);
        wr(32'h10, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("tx_data", TX_DATA, txq.pop_front());
            TX_RD_EN = 1'b1;
            @(negedge PCLK); #1;
        end
        TX_RD_EN = 1'b0;
        chk("tx_empty_after", 32'(TX_EMPTY), 1);
        TX_RD_EN = 1'b1;
        @(negedge PCLK); #1;
        TX_RD_EN = 1'b0;
        rd(32'h10, 32'h0, 1'b0);
        rd(32'h18, 32'h1, 1'b0);

        // RX fill with overflow
        for (int i = 0; i < 9; i++) begin
            d = 32'h5A00_0000 + 32'(i * 3);
            if (rxq.size() < FIFO_DEPTH) rxq.push_back(d);
            RX_WR_EN = 1'b1; RX_DATA = d;
            @(negedge PCLK); #1;
        end
        RX_WR_EN = 1'b0;
        chk("rx_full", 32'(RX_FULL), 1);
        rd(32'h18, 32'h7, 1'b0);
        wr(32'h18, 32'h4, 1'b0);
        rd(32'h18, 32'h3, 1'b0);
        rd(32'h10, 32'h0000_0800, 1'b0);
        for (int i = 0; i < 8; i++) rd(32'h04, rxq.pop_front(), 1'b0);
        rd(32'h10, 32'h0, 1'b0);
        rd(32'h18, 32'h1, 1'b0);

        // ERROR edge interrupt
        wr(32'h14, 32'h8, 1'b0);
        chk("irq_before", 32'(IRQ), 0);
        ERROR = 1'b1;
        @(negedge PCLK); #1;
        chk("irq_lat1", 32'(IRQ), 0);
        @(negedge PCLK); #1;
        chk("irq_lat2", 32'(IRQ), 1);
        ERROR = 1'b0;
        @(negedge PCLK); #1;
        rd(32'h18, 32'h9, 1'b0);
        wr(32'h18, 32'h8, 1'b0, 1);
        rd(32'h18, 32'h9, 1'b0);
        chk("irq_held", 32'(IRQ), 1);
        wr(32'h18, 32'h8, 1'b0);
        rd(32'h18, 32'h1, 1'b0);
        chk("irq_cleared", 32'(IRQ), 0);

        // Same-cycle TX push and pop at level 3
        for (int i = 0; i < 3; i++) begin
            d = 32'hC0DE_0000 + 32'(i);
            txq.push_back(d);
            wr(32'h00, d, 1'b0);
        end
        d = 32'hC0DE_0003;
        wr(32'h00, d, 1'b0, 2);
        txq.push_back(d);
        rd(32'h10, 32'h0000_0003, 1'b0);

        // Unmapped access leaves state untouched
        wr(32'h20, 32'hFFFF_FFFF, 1'b1);
        rd(32'h20, 32'h0, 1'b1);
        rd(32'h10, 32'h0000_0003, 1'b0);
        rd(32'h08, 32'h1234, 1'b0);
        rd(32'h18, 32'h0, 1'b0);
        while (txq.size() > 0) begin
            chk("tx_drain", TX_DATA, txq.pop_front());
            TX_RD_EN = 1'b1;
            @(negedge PCLK); #1;
        end
        TX_RD_EN = 1'b0;
        chk("tx_empty_drain", 32'(TX_EMPTY), 1);

        // Reset in the middle of a TX write: nothing is pushed
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hDEAD_BEEF;
        @(negedge PCLK);
        PENABLE = 1'b1; PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
        #1;
        chk("midrst_tx_empty", 32'(TX_EMPTY), 1);
        chk("midrst_cfg", 32'(I2C_CONFIG), 0);
        chk("midrst_pslverr", 32'(PSLVERR), 0);
        rd(32'h10, 32'h0, 1'b0);
        rd(32'h14, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_i2c_regfile.md
APB_I2C_REGFILE -- requirements
Module: apb_i2c_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning APB data width and FIFO entry width (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning TX and RX FIFO depth in entries (power of 2, 2..64).
REQ-003 SHALL have parameter CFG_W, default 14, meaning width of the CONFIG and TIMEOUT registers (CFG_W <= DATA_W).
REQ-004 SHALL have port PCLK, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port PRESET, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have APB inputs PSELx (1), PENABLE (1), PWRITE (1), PADDR (32), PWDATA (DATA_W).
REQ-007 SHALL have APB outputs PRDATA (DATA_W), PREADY (1) and PSLVERR (1).
REQ-008 SHALL have core-side TX outputs TX_DATA (DATA_W), head of the TX FIFO, and TX_EMPTY (1); TX_RD_EN (1) is an input that pops the TX FIFO.
REQ-009 SHALL have core-side RX inputs RX_WR_EN (1) and RX_DATA (DATA_W), which push the RX FIFO; RX_FULL (1) is an output.
REQ-010 SHALL have input ERROR (1) and outputs I2C_CONFIG (CFG_W), I2C_TIMEOUT (CFG_W) and IRQ (1).

Function
REQ-011 Register map (byte offsets): 0x00 TXDATA (WO, push), 0x04 RXDATA (RO, pop), 0x08 CONFIG (RW), 0x0C TIMEOUT (RW), 0x10 STATUS (RO), 0x14 IRQ_EN (RW, bits[3:0]), 0x18 IRQ_STAT (bits[1:0] RO level, bits[3:2] W1C).
REQ-012 Access phase is PSELx=1 with PENABLE=1; a transfer completes on the rising edge where the access phase and PREADY=1 are both true.
REQ-013 Without wait states, PREADY SHALL be 1 in every access phase; PREADY SHALL be 0 whenever PSELx=0 or PENABLE=0.
REQ-014 A completed write to 0x00 with the TX FIFO not full SHALL push PWDATA; TX_EMPTY SHALL drop the next cycle.
REQ-015 During a read access to 0x04, PRDATA SHALL show the RX FIFO head; completion SHALL pop the head if the FIFO is not empty.
REQ-016 PSLVERR SHALL be 1 in the completing cycle for: an unmapped address, a write to 0x00 with the TX FIFO full (data dropped), a read of 0x04 with the RX FIFO empty (PRDATA=0), a write to a RO register, or a read of 0x00.
REQ-017 A completed write to 0x08 or 0x0C SHALL load PWDATA[CFG_W-1:0] into the register; I2C_CONFIG and I2C_TIMEOUT SHALL reflect the new value the cycle after completion.
REQ-018 STATUS SHALL read {RX level [15:8], TX level [7:0]}, zero-extended; the level counts 0..FIFO_DEPTH inclusive.
REQ-019 A simultaneous push and pop on the same FIFO SHALL both take effect with the count unchanged; on an empty FIFO the pop is ignored and the push applies.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; full is count==FIFO_DEPTH and empty is count==0.
REQ-021 TX_RD_EN while TX_EMPTY=1 SHALL be ignored.
REQ-022 RX_WR_EN while RX_FULL=1 SHALL drop the data and set IRQ_STAT[2] (rx overflow).
REQ-023 IRQ_STAT[0] SHALL equal TX_EMPTY and IRQ_STAT[1] SHALL equal RX not empty.
REQ-024 IRQ_STAT[3] SHALL be set on a 0->1 transition of ERROR.
REQ-025 Writing 1 to IRQ_STAT[3:2] SHALL clear the matching bit; if a set event occurs in the same cycle, set wins.
REQ-026 IRQ SHALL be registered: IRQ = |(IRQ_STAT & IRQ_EN) one cycle later.
REQ-027 Registers, FIFOs and IRQ SHALL be unaffected by non-completing cycles.

Reset
REQ-028 While PRESET=1 at a clock edge, SHALL clear: FIFOs (TX_EMPTY=1, RX_FULL=0, levels 0), CONFIG, TIMEOUT, IRQ_EN, IRQ_STAT sticky bits, IRQ, and the ERROR edge detector; any in-flight APB transfer SHALL be abandoned with no side effect.
REQ-029 After reset, PREADY=0 and PSLVERR=0 until the next access phase.

Configuration
REQ-030 With macro APB_I2C_WAIT_STATE_EN defined, PREADY SHALL be 0 in the first cycle of every access phase and 1 in the second, and all side effects SHALL occur only at that second edge.
REQ-031 Without APB_I2C_WAIT_STATE_EN, behaviour SHALL be as in REQ-013 (zero wait states).

Verification
REQ-032 Reset, then write 0x0000_1234 to 0x08 -> I2C_CONFIG=0x1234 next cycle, PSLVERR=0; read 0x08 -> 0x1234.
REQ-033 FIFO_DEPTH=8: 9 writes to 0x00 -> STATUS=0x0008, 9th write PSLVERR=1; core pops 8 times -> TX_DATA in write order, then TX_EMPTY=1.
REQ-034 Read 0x04 with RX empty -> PSLVERR=1, PRDATA=0; 8 RX_WR_EN pushes plus a 9th -> IRQ_STAT[2]=1; W1C 0x4 to 0x18 -> bit clears.
REQ-035 IRQ_EN=0x8, pulse ERROR -> IRQ=1 two cycles after the rising edge; W1C 0x8 in the same cycle as a new ERROR edge -> bit stays 1.
REQ-036 Same-cycle TX push and TX_RD_EN at level 3 -> level stays 3; access to 0x20 -> PSLVERR=1 with no state change.
REQ-037 With APB_I2C_WAIT_STATE_EN defined: each access takes 2 PREADY cycles; PRESET asserted mid-access -> no push occurs.
